multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Sequencing FSM that drives a multicycle variant of the RV32I core datapath.
- One shared memory port serves both instruction fetch and load/store, and the ALU doubles as the PC adder.
- Emits per-state datapath strobes and mux selects, plus a request/ready handshake toward memory.
- Sits beside the datapath; consumes the opcode and funct fields from the instruction register, and the ALU Zero flag.

Parameters:
- RESET_STATE, 4'd0, state entered on reset (FETCH).

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- op  input  7  Instr[6:0] from IR.
- funct3  input  3  Instr[14:12].
- funct7b5  input  1  Instr[30].
- Zero  input  1  ALU zero flag.
- mem_ready  input  1  memory completes the current access this cycle.
- mem_req  output  1  memory access requested.
- MemWrite  output  1  store strobe; valid only while mem_req=1.
- AdrSrc  output  1  memory address select: 0=PC, 1=ALUOut.
- IRWrite  output  1  load the instruction register.
- PCWrite  output  1  load PC from Result.
- RegWrite  output  1  register file write enable.
- ResultSrc  output  2  00=ALUOut, 01=Data, 10=ALUResult.
- ALUSrcA  output  2  00=PC, 01=OldPC, 10=rs1 register A.
- ALUSrcB  output  2  00=rs2 register, 01=ImmExt, 10=constant 4.
- ImmSrc  output  2  00=I, 01=S, 10=B, 11=J; combinational from op.
- ALUControl  output  4  0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLT, 0110 SLL, 0111 SRL, 1000 SRA, 1001 SLTU.
- illegal  output  1  one-cycle pulse in DECODE on an unsupported opcode.

Behaviour:
- Reset (reset=0, asynchronous): state=FETCH. While reset is held, every output except ImmSrc and ALUControl is 0.
- Reset asserted mid-access drops mem_req immediately; no handshake completion is owed to memory.
- Strobes are Moore outputs of the state. Exceptions: PCWrite and IRWrite in FETCH are gated by mem_ready; PCWrite in BRANCH is gated by the branch-taken condition.
- FETCH: mem_req=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ADD, ResultSrc=10.
  - Holds until mem_ready=1. In that cycle IRWrite=PCWrite=1 and the FSM goes to DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, ADD (branch/jump target into ALUOut). Next state by op:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECUTER
  - 0010011 → EXECUTEI
  - 1100011 → BRANCH
  - 1101111 → JAL
  - anything else → illegal=1, next FETCH. The PC is already advanced, so the instruction acts as a NOP.
- MEMADR: ALUSrcA=10, ALUSrcB=01, ADD. Next MEMREAD if op=0000011, else MEMWRITE.
- MEMREAD: mem_req=1, AdrSrc=1, ResultSrc=00. Waits for mem_ready, then MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1. Next FETCH.
- MEMWRITE: mem_req=1, MemWrite=1, AdrSrc=1, ResultSrc=00. Waits for mem_ready, then FETCH.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUControl from alu_decoder. Next ALUWB.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUControl from alu_decoder. Next ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1. Next FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=00, SUB, ResultSrc=00.
  - PCWrite = Zero when funct3=000 (beq); PCWrite = ~Zero when funct3=001 (bne).
  - Any other funct3: not taken.
  - Next FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ADD, ResultSrc=00, PCWrite=1. Next ALUWB, which writes PC+4 to rd.
- alu_decoder rules:
  - R-type: SUB only when funct3=000 and funct7b5=1.
  - I-type: funct7b5 is ignored except to select SRA vs SRL (funct3=101).
- Handshake:
  - mem_req stays high until the mem_ready cycle.
  - The address source and MemWrite stay stable while waiting.
  - mem_ready outside a request state is ignored.
- Latency: 4 cycles for R/I/JAL, 3 for branch, 4 for sw, 5 for lw, each with zero wait states. Each wait state adds 1 cycle.

Optional Feature:
- Macro INSTRET_CNT_EN.
- Defined: adds output instret (32 bits), reset to 0.
  - Increments by 1 on each transition into FETCH from ALUWB, MEMWB, MEMWRITE, or BRANCH.
  - Illegal opcodes do not increment it.
  - Wraps from 0xFFFFFFFF to 0.
- Undefined: the port and the counter are absent.

Decomposition:
- Package riscv_ctrl_pkg holds:
  - state localparams (FETCH=0 … JAL=10)
  - opcode constants
  - ALUControl codes
  - ImmSrc, ResultSrc, ALUSrcA and ALUSrcB encodings
- One sub-module, alu_decoder: combinational; maps (state class, funct3, funct7b5, op[5]) to ALUControl.

Test Plan:
- Reset release with mem_ready tied 1 → cycle 1: mem_req=1, AdrSrc=0, IRWrite=1, PCWrite=1; cycle 2: state DECODE.
- R-type sub (op=0110011, funct3=000, funct7b5=1) → EXECUTER drives ALUControl=0001; ALUWB drives RegWrite=1 and ResultSrc=00; back in FETCH on cycle 5.
- lw with mem_ready low for 3 cycles in MEMREAD → mem_req and AdrSrc=1 held 4 cycles; then MEMWB with ResultSrc=01 and RegWrite=1.
- beq: Zero=1 → PCWrite=1 in BRANCH. bne: Zero=1 → PCWrite=0.
- op=1111111 → illegal pulses once in DECODE; next state FETCH; no RegWrite or MemWrite asserted.
- Reset asserted during MEMWRITE wait → mem_req and MemWrite drop asynchronously; after release, FETCH. With INSTRET_CNT_EN defined, instret reads 0.

Source files
------------

// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle RV32I controller: FSM states, opcodes,
// ALU control codes and datapath mux selects.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLT  = 4'b0101,
    ALU_SLL  = 4'b0110,
    ALU_SRL  = 4'b0111,
    ALU_SRA  = 4'b1000,
    ALU_SLTU = 4'b1001
  } alu_ctrl_t;

  // Operation class handed from the FSM to the ALU decoder.
  typedef enum logic [1:0] {
    ALU_OP_ADD   = 2'b00,
    ALU_OP_SUB   = 2'b01,
    ALU_OP_FUNCT = 2'b10
  } alu_op_t;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_REG   = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  function automatic logic [1:0] imm_src(input logic [6:0] op);
    case (op)
      OP_STORE:  return IMM_S;
      OP_BRANCH: return IMM_B;
      OP_JAL:    return IMM_J;
      default:   return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath/memory bundle: instruction fields and flags in,
// strobes, mux selects and the memory request out.
interface multicycle_controller_if;
  import riscv_ctrl_pkg::*;

  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       mem_ready;

  logic       mem_req;
  logic       MemWrite;
  logic       AdrSrc;
  logic       IRWrite;
  logic       PCWrite;
  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ImmSrc;
  alu_ctrl_t  ALUControl;
  logic       illegal;

  modport master (
    input  op, funct3, funct7b5, Zero, mem_ready,
    output mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal
  );

  modport slave (
    output op, funct3, funct7b5, Zero, mem_ready,
    input  mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal
  );

endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// Combinational ALU decoder: FSM operation class plus funct fields to ALUControl.
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  alu_op_t    aluOp_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  input  logic       op5_i,
  output alu_ctrl_t  aluControl_o
);

  // op[5] separates R-type from I-type, so addi never turns into a subtract.
  always_comb begin
    aluControl_o = ALU_ADD;
    case (aluOp_i)
      ALU_OP_SUB: aluControl_o = ALU_SUB;
      ALU_OP_FUNCT: begin
        case (funct3_i)
          3'b000:  aluControl_o = (op5_i && funct7b5_i) ? ALU_SUB : ALU_ADD;
          3'b001:  aluControl_o = ALU_SLL;
          3'b010:  aluControl_o = ALU_SLT;
          3'b011:  aluControl_o = ALU_SLTU;
          3'b100:  aluControl_o = ALU_XOR;
          3'b101:  aluControl_o = funct7b5_i ? ALU_SRA : ALU_SRL;
          3'b110:  aluControl_o = ALU_OR;
          default: aluControl_o = ALU_AND;
        endcase
      end
      default: aluControl_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I sequencing FSM with a shared memory port handshake.
// Optional retired-instruction counter enabled by `define INSTRET_CNT_EN.
module multicycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input logic clk,
  input logic reset,
  multicycle_controller_if.master ctrl
`ifdef INSTRET_CNT_EN
  ,
  output logic [31:0] instret
`endif
);

  state_t     state_q, state_d;
  logic       memReq, memWrite, adrSrc, irWrite, pcWrite, regWrite, illegalOp;
  logic [1:0] resultSrc, aluSrcA, aluSrcB;
  alu_op_t    aluOp;
  logic       branchTaken;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= state_t'(RESET_STATE);
    else        state_q <= state_d;
  end

  always_comb begin
    case (ctrl.funct3)
      3'b000:  branchTaken = ctrl.Zero;
      3'b001:  branchTaken = ~ctrl.Zero;
      default: branchTaken = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    memReq    = 1'b0;
    memWrite  = 1'b0;
    adrSrc    = 1'b0;
    irWrite   = 1'b0;
    pcWrite   = 1'b0;
    regWrite  = 1'b0;
    illegalOp = 1'b0;
    resultSrc = RES_ALUOUT;
    aluSrcA   = SRCA_PC;
    aluSrcB   = SRCB_REG;
    aluOp     = ALU_OP_ADD;
    case (state_q)
      FETCH: begin
        memReq    = 1'b1;
        aluSrcB   = SRCB_FOUR;
        resultSrc = RES_ALURESULT;
        if (ctrl.mem_ready) begin
          irWrite = 1'b1;
          pcWrite = 1'b1;
          state_d = DECODE;
        end
      end
      DECODE: begin
        aluSrcA = SRCA_OLDPC;
        aluSrcB = SRCB_IMM;
        case (ctrl.op)
          OP_LOAD, OP_STORE: state_d = MEMADR;
          OP_RTYPE:          state_d = EXECUTER;
          OP_ITYPE:          state_d = EXECUTEI;
          OP_BRANCH:         state_d = BRANCH;
          OP_JAL:            state_d = JAL;
          default: begin
            illegalOp = 1'b1;
            state_d   = FETCH;
          end
        endcase
      end
      MEMADR: begin
        aluSrcA = SRCA_REG;
        aluSrcB = SRCB_IMM;
        state_d = (ctrl.op == OP_LOAD) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        memReq = 1'b1;
        adrSrc = 1'b1;
        if (ctrl.mem_ready) state_d = MEMWB;
      end
      MEMWB: begin
        resultSrc = RES_DATA;
        regWrite  = 1'b1;
        state_d   = FETCH;
      end
      MEMWRITE: begin
        memReq   = 1'b1;
        memWrite = 1'b1;
        adrSrc   = 1'b1;
        if (ctrl.mem_ready) state_d = FETCH;
      end
      EXECUTER: begin
        aluSrcA = SRCA_REG;
        aluOp   = ALU_OP_FUNCT;
        state_d = ALUWB;
      end
      EXECUTEI: begin
        aluSrcA = SRCA_REG;
        aluSrcB = SRCB_IMM;
        aluOp   = ALU_OP_FUNCT;
        state_d = ALUWB;
      end
      ALUWB: begin
        regWrite = 1'b1;
        state_d  = FETCH;
      end
      BRANCH: begin
        aluSrcA = SRCA_REG;
        aluOp   = ALU_OP_SUB;
        pcWrite = branchTaken;
        state_d = FETCH;
      end
      JAL: begin
        aluSrcA = SRCA_OLDPC;
        aluSrcB = SRCB_FOUR;
        pcWrite = 1'b1;
        state_d = ALUWB;
      end
      default: state_d = FETCH;
    endcase
  end

  alu_decoder u_alu_decoder (
    .aluOp_i      (aluOp),
    .funct3_i     (ctrl.funct3),
    .funct7b5_i   (ctrl.funct7b5),
    .op5_i        (ctrl.op[5]),
    .aluControl_o (ctrl.ALUControl)
  );

  // Gating by the reset pin drops an in-flight memory request without waiting for a clock.
  assign ctrl.mem_req   = reset & memReq;
  assign ctrl.MemWrite  = reset & memWrite;
  assign ctrl.AdrSrc    = reset & adrSrc;
  assign ctrl.IRWrite   = reset & irWrite;
  assign ctrl.PCWrite   = reset & pcWrite;
  assign ctrl.RegWrite  = reset & regWrite;
  assign ctrl.illegal   = reset & illegalOp;
  assign ctrl.ResultSrc = reset ? resultSrc : 2'b00;
  assign ctrl.ALUSrcA   = reset ? aluSrcA : 2'b00;
  assign ctrl.ALUSrcB   = reset ? aluSrcB : 2'b00;
  assign ctrl.ImmSrc    = imm_src(ctrl.op);

`ifdef INSTRET_CNT_EN
  logic [31:0] instret_q, instret_d;
  logic        retire;

  // Illegal opcodes return to FETCH from DECODE and are deliberately not counted.
  assign retire = (state_d == FETCH) &&
                  ((state_q == ALUWB) || (state_q == MEMWB) ||
                   (state_q == MEMWRITE) || (state_q == BRANCH));
  assign instret_d = retire ? instret_q + 32'd1 : instret_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) instret_q <= 32'd0;
    else        instret_q <= instret_d;
  end

  assign instret = instret_q;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: directed per-cycle vectors are queued
// by the stimulus and popped by a negedge monitor.
module tb_multicycle_controller;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  multicycle_controller_if bus();

`ifdef INSTRET_CNT_EN
  logic [31:0] instret;
`endif

  multicycle_controller dut (
    .clk   (clk),
    .reset (reset),
    .ctrl  (bus)
`ifdef INSTRET_CNT_EN
    ,
    .instret (instret)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [18:0] vec;
    logic        chkCnt;
    logic [31:0] cnt;
  } exp_t;

  exp_t expQ[$];

  logic [18:0] actVec;
  assign actVec = {bus.mem_req, bus.MemWrite, bus.AdrSrc, bus.IRWrite, bus.PCWrite,
                   bus.RegWrite, bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ImmSrc,
                   bus.ALUControl, bus.illegal};

  // Field order: mem_req MemWrite AdrSrc IRWrite PCWrite RegWrite ResultSrc ALUSrcA ALUSrcB ImmSrc ALUControl illegal
  function automatic logic [18:0] mk(input logic mr, mw, as, ir, pw, rw,
                                     input logic [1:0] res, srcA, srcB, imm,
                                     input logic [3:0] alu, input logic ill);
    return {mr, mw, as, ir, pw, rw, res, srcA, srcB, imm, alu, ill};
  endfunction

  task automatic checkOutput(input exp_t e);
    checks++;
    if (actVec !== e.vec) begin
      failures++;
      $display("[TB] FAIL %s: got %b expected %b", e.name, actVec, e.vec);
    end
`ifdef INSTRET_CNT_EN
    if (e.chkCnt) begin
      checks++;
      if (instret !== e.cnt) begin
        failures++;
        $display("[TB] FAIL %s_instret: got %0d expected %0d", e.name, instret, e.cnt);
      end
    end
`endif
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput(e);
      end
    end
  end

  task automatic pushExp(input string name, input logic [18:0] vec,
                         input logic chk, input logic [31:0] cnt);
    exp_t e;
    e.name   = name;
    e.vec    = vec;
    e.chkCnt = chk;
    e.cnt    = cnt;
    expQ.push_back(e);
  endtask

  task automatic applyStimulus(input string name, input logic rdy, input logic zero,
                               input logic [18:0] vec, input logic chk = 1'b0,
                               input logic [31:0] cnt = 32'd0);
    bus.mem_ready = rdy;
    bus.Zero      = zero;
    pushExp(name, vec, chk, cnt);
    @(posedge clk);
    #1;
  endtask

  task automatic setInstr(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    bus.op       = op;
    bus.funct3   = f3;
    bus.funct7b5 = f7;
  endtask

  initial begin
    bus.mem_ready = 1'b1;
    bus.Zero      = 1'b0;
    setInstr(7'b0110011, 3'b000, 1'b1);
    @(posedge clk);
    #1;
    applyStimulus("reset_hold0", 1, 0, mk(0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 4'b0000,0));
    applyStimulus("reset_hold1", 1, 0, mk(0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 4'b0000,0), 1'b1, 32'd0);
    reset = 1'b1;

    applyStimulus("rsub_fetch",  1, 0, mk(1,0,0,1,1,0, 2'b10,2'b00,2'b10,2'b00, 4'b0000,0), 1'b1, 32'd0);
    applyStimulus("rsub_decode", 1, 0, mk(0,0,0,0,0,0, 2'b00,2'b01,2'b01,2'b00, 4'b0000,0));
    applyStimulus("rsub_exec",   1, 0, mk(0,0,0,0,0,0, 2'b00,2'b10,2'b00,2'b00, 4'b0001,0));
    applyStimulus("rsub_wb",     1, 0, mk(0,0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00, 4'b0000,0));

    setInstr(7'b0010011, 3'b101, 1'b1);
    applyStimulus("srai_fetch",  1, 0, mk(1,0,0,1,1,0, 2'b10,2'b00,2'b10,2'b00, 4'b0000,0), 1'b1, 32'd1);
    applyStimulus("srai_decode", 1, 0, mk(0,0,0,0,0,0, 2'b00,2'b01,2'b01,2'b00, 4'b0000,0));
    applyStimulus("srai_exec",   1, 0, mk(0,0,0,0,0,0, 2'b00,2'b10,2'b01,2'b00, 4'b1000,0));
    applyStimulus("srai_wb",     1, 0, mk(0,0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00, 4'b0000,0));

    setInstr(7'b0010011, 3'b000, 1'b1);
    applyStimulus("addi_fetch",  1, 0, mk(1,0,0,1,1,0, 2'b10,2'b00,2'b10,2'b00, 4'b0000,0), 1'b1, 32'd2);
    applyStimulus("addi_decode", 1, 0, mk(0,0,0,0,0,0, 2'b00,2'b01,2'b01,2'b00, 4'b0000,0));
    applyStimulus("addi_exec",   1, 0, mk(0,0,0,0,0,0, 2'b00,2'b10,2'b01,2'b00, 4'b0000,0));
    applyStimulus("addi_wb",     1, 0, mk(0,0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00, 4'b0000,0));

    setInstr(7'b0000011, 3'b010, 1'b0);
    applyStimulus("lw_fetch_wait", 0, 0, mk(1,0,0,0,0,0, 2'b10,2'b00,2'b10,2'b00, 4'b0000,0), 1'b1, 32'd3);
    applyStimulus("lw_fetch",      1, 0, mk(1,0,0,1,1,0, 2'b10,2'b00,2'b10,2'b00, 4'b0000,0));
    applyStimulus("lw_decode",     1, 0, mk(0,0,0,0,0,0, 2'b00,2'b01,2'b01,2'b00, 4'b0000,0));
    applyStimulus("lw_memadr",     1, 0, mk(0,0,0,0,0,0, 2'b00,2'b10,2'b01,2'b00, 4'b0000,0));
    for (int i = 0; i < 3; i++)
      applyStimulus("lw_read_wait", 0, 0, mk(1,0,1,0,0,0, 2'b00,2'b00,2'b00,2'b00, 4'b0000,0));
    applyStimulus("lw_read",       1, 0, mk(1,0,1,0,0,0, 2'b00,2'b00,2'b00,2'b00, 4'b0000,0));
    applyStimulus("lw_memwb",      1, 0, mk(0,0,0,0,0,1, 2'b01,2'b00,2'b00,2'b00, 4'b0000,0));

    setInstr(7'b0100011, 3'b010, 1'b0);
    applyStimulus("sw_fetch",  1, 0, mk(1,0,0,1,1,0, 2'b10,2'b00,2'b10,2'b01, 4'b0000,0), 1'b1, 32'd4);
    applyStimulus("sw_decode", 1, 0, mk(0,0,0,0,0,0, 2'b00,2'b01,2'b01,2'b01, 4'b0000,0));
    applyStimulus("sw_memadr", 1, 0, mk(0,0,0,0,0,0, 2'b00,2'b10,2'b01,2'b01, 4'b0000,0));
    applyStimulus("sw_write",  1, 0, mk(1,1,1,0,0,0, 2'b00,2'b00,2'b00,2'b01, 4'b0000,0));

    setInstr(7'b1100011, 3'b000, 1'b0);
    applyStimulus("beq_fetch",  1, 0, mk(1,0,0,1,1,0, 2'b10,2'b00,2'b10,2'b10, 4'b0000,0), 1'b1, 32'd5);
    applyStimulus("beq_decode", 1, 0, mk(0,0,0,0,0,0, 2'b00,2'b01,2'b01,2'b10, 4'b0000,0));
    applyStimulus("beq_z1",     1, 1, mk(0,0,0,0,1,0, 2'b00,2'b10,2'b00,2'b10, 4'b0001,0));

    setInstr(7'b1100011, 3'b001, 1'b0);
    applyStimulus("bne_fetch",  1, 0, mk(1,0,0,1,1,0, 2'b10,2'b00,2'b10,2'b10, 4'b0000,0), 1'b1, 32'd6);
    applyStimulus("bne_decode", 1, 0, mk(0,0,0,0,0,0, 2'b00,2'b01,2'b01,2'b10, 4'b0000,0));
    applyStimulus("bne_z1",     1, 1, mk(0,0,0,0,0,0, 2'b00,2'b10,2'b00,2'b10, 4'b0001,0));
    applyStimulus("bne2_fetch", 1, 0, mk(1,0,0,1,1,0, 2'b10,2'b00,2'b10,2'b10, 4'b0000,0), 1'b1, 32'd7);
    applyStimulus("bne2_decode",1, 0, mk(0,0,0,0,0,0, 2'b00,2'b01,2'b01,2'b10, 4'b0000,0));
    applyStimulus("bne_z0",     1, 0, mk(0,0,0,0,1,0, 2'b00,2'b10,2'b00,2'b10, 4'b0001,0));

    setInstr(7'b1100011, 3'b100, 1'b0);
    applyStimulus("blt_fetch",  1, 0, mk(1,0,0,1,1,0, 2'b10,2'b00,2'b10,2'b10, 4'b0000,0), 1'b1, 32'd8);
    applyStimulus("blt_decode", 1, 0, mk(0,0,0,0,0,0, 2'b00,2'b01,2'b01,2'b10, 4'b0000,0));
    applyStimulus("blt_z1",     1, 1, mk(0,0,0,0,0,0, 2'b00,2'b10,2'b00,2'b10, 4'b0001,0));

    setInstr(7'b1101111, 3'b000, 1'b0);
    applyStimulus("jal_fetch",  1, 0, mk(1,0,0,1,1,0, 2'b10,2'b00,2'b10,2'b11, 4'b0000,0), 1'b1, 32'd9);
    applyStimulus("jal_decode", 1, 0, mk(0,0,0,0,0,0, 2'b00,2'b01,2'b01,2'b11, 4'b0000,0));
    applyStimulus("jal_exec",   1, 0, mk(0,0,0,0,1,0, 2'b00,2'b01,2'b10,2'b11, 4'b0000,0));
    applyStimulus("jal_wb",     1, 0, mk(0,0,0,0,0,1, 2'b00,2'b00,2'b00,2'b11, 4'b0000,0));

    setInstr(7'b1111111, 3'b000, 1'b0);
    applyStimulus("ill_fetch",  1, 0, mk(1,0,0,1,1,0, 2'b10,2'b00,2'b10,2'b00, 4'b0000,0), 1'b1, 32'd10);
    applyStimulus("ill_decode", 1, 0, mk(0,0,0,0,0,0, 2'b00,2'b01,2'b01,2'b00, 4'b0000,1));

    // Illegal opcode must land back in FETCH without bumping instret.
    setInstr(7'b0100011, 3'b010, 1'b0);
    applyStimulus("sw2_fetch",  1, 0, mk(1,0,0,1,1,0, 2'b10,2'b00,2'b10,2'b01, 4'b0000,0), 1'b1, 32'd10);
    applyStimulus("sw2_decode", 1, 0, mk(0,0,0,0,0,0, 2'b00,2'b01,2'b01,2'b01, 4'b0000,0));
    applyStimulus("sw2_memadr", 1, 0, mk(0,0,0,0,0,0, 2'b00,2'b10,2'b01,2'b01, 4'b0000,0));
    applyStimulus("sw2_wait",   0, 0, mk(1,1,1,0,0,0, 2'b00,2'b00,2'b00,2'b01, 4'b0000,0));

    bus.mem_ready = 1'b0;
    #2;
    reset = 1'b0;
    pushExp("rst_mid", mk(0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b01, 4'b0000,0), 1'b1, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    applyStimulus("post_rst_fetch", 0, 0, mk(1,0,0,0,0,0, 2'b10,2'b00,2'b10,2'b01, 4'b0000,0), 1'b1, 32'd0);

    repeat (3) @(negedge clk);
    checks++;
    if (expQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain: got %0d pending expected 0", expQ.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
